mining_bram_responder: RTL and testbench

- Memory-side responder for the mining controller's BRAM strobe interface.
- Holds DEPTH lines of 512 bits each. Services active-low chip-select/write/read strobes issued by the mining FSM.
- Writes merge a 32-bit word into a line at a caller-supplied MSB bit position. Reads return a whole line one cycle later.
- Zero-initialises itself after reset, with a hardware sweep.

---
 rtl/mining_bram_responder.sv | 88 ++++++++
 tb/tb_mining_bram_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mining_bram_responder.sv
// Line memory for the mining FSM's strobe bus: word-merge writes, whole-line reads one cycle later.
// No backpressure: strobes are ignored until the post-reset zero sweep completes.
module mining_bram_responder #(
  parameter int DEPTH  = 64,
  parameter int LINE_W = 512,
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [15:0]       addr,
  input  logic [8:0]        addr_width,
  input  logic [WORD_W-1:0] bram_data_in,
  output logic [LINE_W-1:0] bram_data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     ptr;
  logic [LINE_W-1:0] mem [DEPTH];

  logic          req_wr, req_rd, illegal, do_wr, do_rd;
  logic [AW-1:0] idx;

  assign idx   = addr[AW-1:0];
  assign ready = (state == RUN);

  always_comb begin
    state_nxt = state;
    req_wr    = 1'b0;
    req_rd    = 1'b0;
    illegal   = 1'b0;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    case (state)
      INIT: if (ptr == AW'(DEPTH - 1)) state_nxt = RUN;
      RUN: begin
        // Gating on reset drops any access coinciding with a reset edge.
        if (!cs_n && !reset) begin
          req_wr = !wr_n;
          req_rd = !rd_n;
        end
      end
      default: state_nxt = INIT;
    endcase
    illegal = (req_wr || req_rd) &&
              ((addr >= 16'(DEPTH)) || (req_wr && (addr_width < 9'(WORD_W - 1))));
    do_wr = req_wr && !illegal;
    do_rd = req_rd && !illegal;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= INIT;
      ptr           <= '0;
      bram_data_out <= '0;
      rd_valid      <= 1'b0;
      err           <= 1'b0;
      wr_count      <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= do_rd;
      if (state == INIT) ptr <= ptr + 1'b1;
      if (do_rd) bram_data_out <= mem[idx];
      if (do_wr) wr_count <= wr_count + 16'd1;
      if (illegal) err <= 1'b1;
    end
  end

  // Read above samples the pre-write line, giving read-first on same-cycle collisions.
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      mem[ptr] <= '0;
    end else if (do_wr) begin
      mem[idx][addr_width -: WORD_W] <= bram_data_in;
    end
  end

endmodule

// File: tb/tb_mining_bram_responder.sv
// Directed bench for mining_bram_responder: init sweep, merges, read-first, illegal access, reset.
module tb_mining_bram_responder;

  logic         clock = 1'b0;
  logic         reset;
  logic         cs_n, wr_n, rd_n;
  logic [15:0]  addr;
  logic [8:0]   addr_width;
  logic [31:0]  bram_data_in;
  logic [511:0] bram_data_out;
  logic         rd_valid, ready, err;
  logic [15:0]  wr_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mining_bram_responder dut (
    .clock(clock), .reset(reset), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .addr_width(addr_width), .bram_data_in(bram_data_in),
    .bram_data_out(bram_data_out), .rd_valid(rd_valid), .ready(ready),
    .err(err), .wr_count(wr_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [8:0] aw, input logic [31:0] d);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
    addr = a; addr_width = aw; bram_data_in = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [15:0] a, output logic vld, output logic [511:0] line);
    cs_n = 1'b0; wr_n = 1'b1; rd_n = 1'b0; addr = a;
    tick();
    vld = rd_valid; line = bram_data_out;
    idle();
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic bad;
    reset = 1'b1; idle(); addr = '0; addr_width = '0; bram_data_in = '0;
    tick(); tick();
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_chk++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
    n_chk++; if (bram_data_out !== 512'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bram_data_out); end
    reset = 1'b0;
    // Strobes during the sweep (including an illegal address) must have no effect.
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 16'd100; addr_width = 9'd5;
    cyc = 0; bad = 1'b0;
    while (!ready && cyc < 200) begin
      tick();
      cyc++;
      if (rd_valid !== 1'b0 || err !== 1'b0) bad = 1'b1;
      if (cyc == 10) idle();
    end
    n_chk++; if (cyc !== 64) begin n_fail++; $display("FAIL init_cycles got %0d want 64", cyc); end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL init_strobes_ignored got %b want 0", bad); end
    n_chk++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL init_wr_count got %0d want 0", wr_count); end
  endtask

  task automatic test_init_read();
    logic v; logic [511:0] d;
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL pre_read_valid got %b want 0", rd_valid); end
    do_read(16'd63, v, d);
    n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL init_read_valid got %b want 1", v); end
    n_chk++; if (d !== 512'd0) begin n_fail++; $display("FAIL init_read_data got %h want 0", d); end
    tick();
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL init_read_pulse got %b want 0", rd_valid); end
  endtask

  task automatic test_merge();
    logic v; logic [511:0] d, exp;
    do_write(16'd3, 9'd511, 32'hDEADBEEF);
    do_write(16'd3, 9'd31, 32'h00000001);
    do_read(16'd3, v, d);
    exp = '0; exp[511:480] = 32'hDEADBEEF; exp[31:0] = 32'h1;
    n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL merge_valid got %b want 1", v); end
    n_chk++; if (d !== exp) begin n_fail++; $display("FAIL merge_line got %h want %h", d, exp); end
    n_chk++; if (wr_count !== 16'd2) begin n_fail++; $display("FAIL merge_wr_count got %0d want 2", wr_count); end
  endtask

  task automatic test_nonce();
    logic v; logic [511:0] d, exp;
    do_write(16'd5, 9'd63, 32'h00000010);
    do_read(16'd5, v, d);
    n_chk++; if (v !== 1'b1 || d[63:32] !== 32'h10) begin n_fail++; $display("FAIL nonce_read1 got v=%b f=%h want v=1 f=00000010", v, d[63:32]); end
    do_write(16'd5, 9'd63, d[63:32] + 32'd1);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL nonce_valid_drop got %b want 0", rd_valid); end
    n_chk++; if (bram_data_out[63:32] !== 32'h10) begin n_fail++; $display("FAIL nonce_data_hold got %h want 00000010", bram_data_out[63:32]); end
    do_read(16'd5, v, d);
    exp = '0; exp[63:32] = 32'h11;
    n_chk++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL nonce_read2 got v=%b %h want v=1 %h", v, d, exp); end
    n_chk++; if (wr_count !== 16'd4) begin n_fail++; $display("FAIL nonce_wr_count got %0d want 4", wr_count); end
  endtask

  task automatic test_back_to_back();
    logic v; logic [511:0] d, exp;
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
    addr = 16'd7; addr_width = 9'd95; bram_data_in = 32'hA5A5A5A5;
    repeat (4) tick();
    idle();
    n_chk++; if (wr_count !== 16'd8) begin n_fail++; $display("FAIL held_wr_count got %0d want 8", wr_count); end
    do_read(16'd7, v, d);
    exp = '0; exp[95:64] = 32'hA5A5A5A5;
    n_chk++; if (d !== exp) begin n_fail++; $display("FAIL held_line got %h want %h", d, exp); end
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; bram_data_in = 32'h12345678;
    tick();
    idle();
    n_chk++; if (rd_valid !== 1'b1 || bram_data_out[95:64] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL read_first got v=%b f=%h want v=1 f=a5a5a5a5", rd_valid, bram_data_out[95:64]); end
    n_chk++; if (wr_count !== 16'd9) begin n_fail++; $display("FAIL rw_wr_count got %0d want 9", wr_count); end
    do_read(16'd7, v, d);
    n_chk++; if (d[95:64] !== 32'h12345678) begin n_fail++; $display("FAIL after_rw got %h want 12345678", d[95:64]); end
  endtask

  task automatic test_illegal();
    logic v; logic [511:0] d, exp;
    do_write(16'd64, 9'd31, 32'hFFFFFFFF);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_addr_err got %b want 1", err); end
    n_chk++; if (wr_count !== 16'd9) begin n_fail++; $display("FAIL ill_addr_wr_count got %0d want 9", wr_count); end
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 16'd2; addr_width = 9'd20; bram_data_in = 32'hFFFFFFFF;
    tick();
    idle();
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ill_width_rd_valid got %b want 0", rd_valid); end
    n_chk++; if (wr_count !== 16'd9) begin n_fail++; $display("FAIL ill_width_wr_count got %0d want 9", wr_count); end
    do_read(16'd64, v, d);
    n_chk++; if (v !== 1'b0) begin n_fail++; $display("FAIL ill_read_valid got %b want 0", v); end
    do_read(16'd2, v, d);
    n_chk++; if (v !== 1'b1 || d !== 512'd0) begin n_fail++; $display("FAIL ill_line2 got v=%b %h want v=1 0", v, d); end
    do_write(16'd2, 9'd31, 32'h0000CAFE);
    do_read(16'd2, v, d);
    exp = '0; exp[31:0] = 32'h0000CAFE;
    n_chk++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL legal_after_ill got v=%b %h want v=1 %h", v, d, exp); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
    n_chk++; if (wr_count !== 16'd10) begin n_fail++; $display("FAIL legal_wr_count got %0d want 10", wr_count); end
  endtask

  task automatic test_reset_mid();
    logic v; logic [511:0] d;
    int cyc;
    do_write(16'd9, 9'd127, 32'h99999999);
    n_chk++; if (wr_count !== 16'd11) begin n_fail++; $display("FAIL pre_rst_wr_count got %0d want 11", wr_count); end
    cs_n = 1'b0; wr_n = 1'b1; rd_n = 1'b0; addr = 16'd9; reset = 1'b1;
    tick();
    idle(); reset = 1'b0;
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
    n_chk++; if (ready !== 1'b0 || err !== 1'b0 || wr_count !== 16'd0) begin n_fail++; $display("FAIL rst_state got rdy=%b err=%b cnt=%0d want 0 0 0", ready, err, wr_count); end
    wait_ready(cyc);
    n_chk++; if (cyc !== 64) begin n_fail++; $display("FAIL reinit_cycles got %0d want 64", cyc); end
    do_read(16'd9, v, d);
    n_chk++; if (v !== 1'b1 || d !== 512'd0) begin n_fail++; $display("FAIL reinit_line9 got v=%b %h want v=1 0", v, d); end
    n_chk++; if (err !== 1'b0 || wr_count !== 16'd0) begin n_fail++; $display("FAIL reinit_flags got err=%b cnt=%0d want 0 0", err, wr_count); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_merge();
    test_nonce();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
